// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared states, corelet control bits, SRAM polarity and clog2 helper
package core_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_W_FILL = 3'd1;
    localparam state_t ST_K_LOAD = 3'd2;
    localparam state_t ST_X_FILL = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_DRAIN  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;

    localparam logic SRAM_ON  = 1'b0;
    localparam logic SRAM_OFF = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/core_seq_corelet.sv
// rtl/core_seq_corelet.sv - L0 queue, weight registers, MAC array, output queue and accumulating SFP
module core_seq_corelet
    import core_seq_pkg::*;
#(
    parameter int bw       = 8,
    parameter int psum_bw  = 16,
    parameter int row      = 4,
    parameter int col      = 8,
    parameter int L0_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             inst,
    input  logic                   l0_wr,
    input  logic                   l0_rd,
    input  logic [row*bw-1:0]      l0_in,
    input  logic                   ofifo_rd,
    input  logic                   accum,
    input  logic [col*psum_bw-1:0] sfp_in,
    output logic                   ofifo_valid,
    output logic [col*psum_bw-1:0] sfp_out
);

    localparam int LAW = clog2(L0_DEPTH);
    localparam int KW  = clog2(col);

    logic [row*bw-1:0]      l0_mem [L0_DEPTH];
    logic [col*psum_bw-1:0] of_mem [L0_DEPTH];
    logic [row*bw-1:0]      w_q    [col];
    logic [LAW-1:0]         l0_wp_q, l0_rp_q, of_wp_q, of_rp_q;
    logic [LAW:0]           of_cnt_q;
    logic [KW-1:0]          k_q;
    logic [row*bw-1:0]      head;
    logic [col*psum_bw-1:0] psum;
    logic signed [psum_bw-1:0] acc;
    logic signed [2*bw-1:0]    prod;
    logic load, exec, pop;

    assign head        = l0_mem[l0_rp_q];
    assign load        = l0_rd & inst[INST_LOAD];
    assign exec        = l0_rd & inst[INST_EXEC];
    assign pop         = ofifo_rd & ofifo_valid;
    assign ofifo_valid = (of_cnt_q != '0);

    // Signed dot product of the L0 head vector with each weight column
    always_comb begin
        psum = '0;
        acc  = '0;
        prod = '0;
        for (int c = 0; c < col; c++) begin
            acc = '0;
            for (int r = 0; r < row; r++) begin
                prod = $signed(head[r*bw +: bw]) * $signed(w_q[c][r*bw +: bw]);
                acc  = acc + psum_bw'(prod);
            end
            psum[c*psum_bw +: psum_bw] = acc;
        end
    end

    // SFP adds the pmem word to the ofifo head when accumulating
    always_comb begin
        sfp_out = '0;
        for (int c = 0; c < col; c++) begin
            sfp_out[c*psum_bw +: psum_bw] = of_mem[of_rp_q][c*psum_bw +: psum_bw]
                                          + (accum ? sfp_in[c*psum_bw +: psum_bw] : '0);
        end
    end

    // Queue storage and weight columns, no reset needed
    always_ff @(posedge clk) begin
        if (l0_wr) l0_mem[l0_wp_q] <= l0_in;
        if (load)  w_q[k_q]        <= head;
        if (exec)  of_mem[of_wp_q] <= psum;
    end

    // Queue pointers, occupancy and kernel column index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l0_wp_q  <= '0;
            l0_rp_q  <= '0;
            of_wp_q  <= '0;
            of_rp_q  <= '0;
            of_cnt_q <= '0;
            k_q      <= '0;
        end else begin
            if (l0_wr) l0_wp_q <= l0_wp_q + 1'b1;
            if (l0_rd) l0_rp_q <= l0_rp_q + 1'b1;
            if (load)  k_q     <= (k_q == KW'(col - 1)) ? '0 : k_q + 1'b1;
            if (exec)  of_wp_q <= of_wp_q + 1'b1;
            if (pop)   of_rp_q <= of_rp_q + 1'b1;
            case ({exec, pop})
                2'b10:   of_cnt_q <= of_cnt_q + 1'b1;
                2'b01:   of_cnt_q <= of_cnt_q - 1'b1;
                default: of_cnt_q <= of_cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/core_seq_fsm.sv
// rtl/core_seq_fsm.sv - run sequencer; busy-cycle counter built only with CORE_SEQ_PERF_CNT_EN
module core_seq_fsm
    import core_seq_pkg::*;
#(
    parameter int col       = 8,
    parameter int L0_DEPTH  = 64,
    parameter int FLUSH_CYC = 12,
    parameter int XAW       = 11,
    parameter int PAW       = 11,
    parameter int NW        = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [XAW-1:0] w_base,
    input  logic [XAW-1:0] x_base,
    input  logic [PAW-1:0] p_base,
    input  logic [NW-1:0]  n_x,
    input  logic           accum_en,
    input  logic           ofifo_valid,
    output logic           idle,
    output logic           busy,
    output logic           done,
    output logic           clamp_err,
    output logic [31:0]    perf_cycles,
    output logic           x_cen,
    output logic [XAW-1:0] x_addr,
    output logic           p_cen,
    output logic           p_wen,
    output logic [PAW-1:0] p_addr,
    output logic           l0_wr,
    output logic           l0_rd,
    output logic [1:0]     inst,
    output logic           ofifo_rd,
    output logic           accum
);

    localparam logic [15:0]   COL_C  = 16'(col);
    localparam logic [15:0]   KEND_C = 16'(col + FLUSH_CYC - 1);
    localparam logic [15:0]   FL_M1  = 16'(FLUSH_CYC - 1);
    localparam logic [NW-1:0] L0_MAX = NW'(L0_DEPTH);

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d, neff16;
    logic [NW-1:0]  k_q, k_d, neff_q;
    logic           ph_q, ph_d;
    logic [XAW-1:0] w_base_q, x_base_q;
    logic [PAW-1:0] p_base_q;
    logic           accum_q, clamp_q, l0_wr_q, accept;

    assign neff16    = 16'(neff_q);
    assign accept    = (state_q == ST_IDLE) && start;
    assign idle      = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign busy      = !idle && !done;
    assign clamp_err = clamp_q;
    assign l0_wr     = l0_wr_q;

    // Next state, phase counters and all memory / corelet strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        ph_d     = ph_q;
        x_cen    = SRAM_OFF;
        x_addr   = '0;
        p_cen    = SRAM_OFF;
        p_wen    = SRAM_OFF;
        p_addr   = '0;
        l0_rd    = 1'b0;
        inst     = 2'b00;
        ofifo_rd = 1'b0;
        accum    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_W_FILL;
                    cnt_d   = '0;
                    k_d     = '0;
                    ph_d    = 1'b0;
                end
            end
            ST_W_FILL: begin
                if (cnt_q < COL_C) begin
                    x_cen  = SRAM_ON;
                    x_addr = w_base_q + XAW'(cnt_q);
                end
                if (cnt_q == COL_C) begin
                    state_d = ST_K_LOAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_K_LOAD: begin
                if (cnt_q < COL_C) begin
                    l0_rd           = 1'b1;
                    inst[INST_LOAD] = 1'b1;
                end
                if (cnt_q == KEND_C) begin
                    state_d = (neff_q == '0) ? ST_DONE : ST_X_FILL;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_X_FILL: begin
                if (cnt_q < neff16) begin
                    x_cen  = SRAM_ON;
                    x_addr = x_base_q + XAW'(cnt_q);
                end
                if (cnt_q == neff16) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_EXEC: begin
                if (cnt_q < neff16) begin
                    l0_rd           = 1'b1;
                    inst[INST_EXEC] = 1'b1;
                end
                if (cnt_q == neff16 + FL_M1) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            ST_DRAIN: begin
                p_addr = p_base_q + PAW'(k_q);
                if (accum_q && !ph_q) begin
                    if (ofifo_valid) begin
                        p_cen = SRAM_ON;
                        ph_d  = 1'b1;
                    end
                end else if (ph_q || ofifo_valid) begin
                    p_cen    = SRAM_ON;
                    p_wen    = SRAM_ON;
                    ofifo_rd = 1'b1;
                    accum    = accum_q;
                    ph_d     = 1'b0;
                    k_d      = k_q + 1'b1;
                    if (k_q == neff_q - 1'b1) state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counters and configuration captured on an accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            ph_q     <= 1'b0;
            neff_q   <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            accum_q  <= 1'b0;
            clamp_q  <= 1'b0;
            l0_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
            l0_wr_q <= (x_cen == SRAM_ON);
            if (accept) begin
                w_base_q <= w_base;
                x_base_q <= x_base;
                p_base_q <= p_base;
                accum_q  <= accum_en;
                clamp_q  <= (n_x > L0_MAX);
                neff_q   <= (n_x > L0_MAX) ? L0_MAX : n_x;
            end
        end
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    // Busy-cycle count, restarted by each accepted start and saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   perf_q <= '0;
        else if (accept)              perf_q <= '0;
        else if (busy && perf_q != '1) perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: rtl/core_seq_sram.sv
// rtl/core_seq_sram.sv - 32-bit single-port SRAM slice, active-low enables, 1-cycle read
module core_seq_sram
    import core_seq_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   d,
    output logic [31:0]   q
);

    logic [31:0] mem [DEPTH];

    // Write when enabled with wen low, otherwise read; q holds its value between reads
    always_ff @(posedge clk) begin
        if (cen == SRAM_ON) begin
            if (wen == SRAM_ON) mem[addr] <= d;
            else                q         <= mem[addr];
        end
    end

endmodule

// File: rtl/core_seq.sv
// rtl/core_seq.sv - self-sequencing core top: xmem, pmem, corelet, sequencer (CORE_SEQ_PERF_CNT_EN adds perf_cycles)
module core_seq
    import core_seq_pkg::*;
#(
    parameter int bw         = 8,
    parameter int psum_bw    = 16,
    parameter int row        = 4,
    parameter int col        = 8,
    parameter int XMEM_DEPTH = 2048,
    parameter int PMEM_DEPTH = 2048,
    parameter int L0_DEPTH   = 64,
    parameter int FLUSH_CYC  = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [clog2(XMEM_DEPTH)-1:0]  w_base,
    input  logic [clog2(XMEM_DEPTH)-1:0]  x_base,
    input  logic [clog2(PMEM_DEPTH)-1:0]  p_base,
    input  logic [clog2(L0_DEPTH):0]      n_x,
    input  logic                          accum_en,
    input  logic                          xmem_wr_en,
    input  logic [clog2(XMEM_DEPTH)-1:0]  xmem_wr_addr,
    input  logic [row*bw-1:0]             D_xmem,
    input  logic                          pmem_rd_en,
    input  logic [clog2(PMEM_DEPTH)-1:0]  pmem_rd_addr,
    output logic [col*psum_bw-1:0]        pmem_rd_data,
    output logic                          pmem_rd_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          clamp_err,
    output logic                          ofifo_valid,
    output logic [col*psum_bw-1:0]        sfp_out,
    output logic [31:0]                   perf_cycles
);

    localparam int XAW = clog2(XMEM_DEPTH);
    localparam int PAW = clog2(PMEM_DEPTH);
    localparam int NW  = clog2(L0_DEPTH) + 1;
    localparam int XW  = row * bw;
    localparam int PW  = col * psum_bw;

    logic           idle, seq_x_cen, seq_p_cen, seq_p_wen;
    logic [XAW-1:0] seq_x_addr, x_addr;
    logic [PAW-1:0] seq_p_addr, p_addr;
    logic           x_cen, x_wen, p_cen, p_wen;
    logic [XW-1:0]  x_q;
    logic [PW-1:0]  p_q;
    logic           l0_wr, l0_rd, ofifo_rd, accum, rd_valid_q;
    logic [1:0]     inst;

    // Host access owns the single SRAM ports only while the sequencer is idle
    always_comb begin
        x_cen  = seq_x_cen;
        x_wen  = SRAM_OFF;
        x_addr = seq_x_addr;
        p_cen  = seq_p_cen;
        p_wen  = seq_p_wen;
        p_addr = seq_p_addr;
        if (idle) begin
            x_cen  = xmem_wr_en ? SRAM_ON : SRAM_OFF;
            x_wen  = xmem_wr_en ? SRAM_ON : SRAM_OFF;
            x_addr = xmem_wr_addr;
            p_cen  = pmem_rd_en ? SRAM_ON : SRAM_OFF;
            p_wen  = SRAM_OFF;
            p_addr = pmem_rd_addr;
        end
    end

    // Host read data is valid the cycle after an accepted read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_valid_q <= 1'b0;
        else        rd_valid_q <= idle & pmem_rd_en;
    end

    assign pmem_rd_valid = rd_valid_q;
    assign pmem_rd_data  = rd_valid_q ? p_q : '0;

    for (genvar g = 0; g < XW / 32; g++) begin : g_xmem
        core_seq_sram #(.DEPTH(XMEM_DEPTH), .AW(XAW)) u_sram (
            .clk(clk), .cen(x_cen), .wen(x_wen), .addr(x_addr),
            .d(D_xmem[g*32 +: 32]), .q(x_q[g*32 +: 32])
        );
    end

    for (genvar g = 0; g < PW / 32; g++) begin : g_pmem
        core_seq_sram #(.DEPTH(PMEM_DEPTH), .AW(PAW)) u_sram (
            .clk(clk), .cen(p_cen), .wen(p_wen), .addr(p_addr),
            .d(sfp_out[g*32 +: 32]), .q(p_q[g*32 +: 32])
        );
    end

    core_seq_corelet #(
        .bw(bw), .psum_bw(psum_bw), .row(row), .col(col), .L0_DEPTH(L0_DEPTH)
    ) u_corelet (
        .clk(clk), .reset(reset), .inst(inst), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .l0_in(x_q), .ofifo_rd(ofifo_rd), .accum(accum), .sfp_in(p_q),
        .ofifo_valid(ofifo_valid), .sfp_out(sfp_out)
    );

    core_seq_fsm #(
        .col(col), .L0_DEPTH(L0_DEPTH), .FLUSH_CYC(FLUSH_CYC),
        .XAW(XAW), .PAW(PAW), .NW(NW)
    ) u_fsm (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
        .p_base(p_base), .n_x(n_x), .accum_en(accum_en), .ofifo_valid(ofifo_valid),
        .idle(idle), .busy(busy), .done(done), .clamp_err(clamp_err),
        .perf_cycles(perf_cycles), .x_cen(seq_x_cen), .x_addr(seq_x_addr),
        .p_cen(seq_p_cen), .p_wen(seq_p_wen), .p_addr(seq_p_addr),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .inst(inst), .ofifo_rd(ofifo_rd), .accum(accum)
    );

endmodule
